// File: rtl/regchk_pkg.sv
// rtl/regchk_pkg.sv - shared types and helpers for the register-file shadow checker
//
// Purpose : FSM state enum, error-capture record and address-width helper
//           used by regfile_shadow_checker and regchk_shadow_rf.
// Ports   : none (package).

package regchk_pkg;

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        ERROR = 1'b1
    } chk_state_e;

    // Capture record is sized for the widest supported configuration so it
    // can live in the package; the top slices it down to XLEN / AW.
    localparam int CAP_AW_MAX = 8;
    localparam int CAP_DW_MAX = 64;

    typedef struct packed {
        logic [CAP_AW_MAX-1:0] rnum;
        logic                  port;
        logic [CAP_DW_MAX-1:0] syndrome;
    } err_cap_t;

    function automatic int regchk_aw(input int num_regs);
        return (num_regs > 1) ? $clog2(num_regs) : 1;
    endfunction

endpackage

// File: rtl/regchk_shadow_rf.sv
// rtl/regchk_shadow_rf.sv - shadow register array with per-register valid bits
//
// Purpose : Holds the shadow copy of the architectural register file.
//           One synchronous write port, two asynchronous read ports, and a
//           clear-all of the valid bits. Data words are not reset.
// Ports   : clk, rst (async, active-high), clr (sync clear of valid bits)
//           we / waddr / wdata     write port
//           raddr1 / rdata1        read port 1, rdata1 = {valid, data}
//           raddr2 / rdata2        read port 2, rdata2 = {valid, data}

module regchk_shadow_rf
    import regchk_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int NUM_REGS = 32,
    localparam int AW      = regchk_aw(NUM_REGS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic [AW-1:0]   raddr1,
    output logic [XLEN:0]   rdata1,
    input  logic [AW-1:0]   raddr2,
    output logic [XLEN:0]   rdata2
);

    // Full power-of-two depth so any address indexes safely; entries above
    // NUM_REGS are never written because the top masks them out.
    localparam int DEPTH = 1 << AW;

    logic [XLEN-1:0]  mem [DEPTH];
    logic [DEPTH-1:0] valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= '0;
        end else if (clr) begin
            valid <= '0;
        end else if (we) begin
            valid[waddr] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata1 = {valid[raddr1], mem[raddr1]};
    assign rdata2 = {valid[raddr2], mem[raddr2]};

endmodule

// File: rtl/regfile_shadow_checker.sv
// rtl/regfile_shadow_checker.sv - RVFI register-file consistency monitor
//
// Purpose : Builds a shadow register file from retired writes and checks
//           both source-operand reads of every retirement against it.
//           Reports mismatches through a latched capture record, an error
//           flag and saturating counters.
// Ports   : clk, rst (async, active-high), clr (sync clear)
//           rvfi_valid, rvfi_rd_addr, rvfi_rd_wdata       retirement / write
//           rvfi_rs1_addr/rdata, rvfi_rs2_addr/rdata      source reads
//           err                 error state flag
//           err_syndrome        shadow XOR read data of captured error
//           err_reg, err_port   register and port (0 = rs1, 1 = rs2)
//           check_cnt, err_cnt  saturating counters

module regfile_shadow_checker
    import regchk_pkg::*;
#(
    parameter int                  XLEN       = 32,
    parameter int                  NUM_REGS   = 32,
    parameter logic [NUM_REGS-1:0] CHECK_MASK = {NUM_REGS{1'b1}},
    parameter bit                  STICKY     = 1'b1,
    parameter int                  CNT_W      = 16,
    localparam int                 AW         = regchk_aw(NUM_REGS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             rvfi_valid,
    input  logic [AW-1:0]    rvfi_rd_addr,
    input  logic [XLEN-1:0]  rvfi_rd_wdata,
    input  logic [AW-1:0]    rvfi_rs1_addr,
    input  logic [AW-1:0]    rvfi_rs2_addr,
    input  logic [XLEN-1:0]  rvfi_rs1_rdata,
    input  logic [XLEN-1:0]  rvfi_rs2_rdata,
    output logic             err,
    output logic [XLEN-1:0]  err_syndrome,
    output logic [AW-1:0]    err_reg,
    output logic             err_port,
    output logic [CNT_W-1:0] check_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    localparam int DEPTH = 1 << AW;
    // x0 is never shadowed; addresses beyond NUM_REGS are never monitored.
    localparam logic [DEPTH-1:0] MON_MASK = DEPTH'(CHECK_MASK) & ~(DEPTH'(1));

    chk_state_e      state;
    err_cap_t        cap_q;
    err_cap_t        cap_d;

    logic [XLEN:0]   rd1;
    logic [XLEN:0]   rd2;
    logic [XLEN-1:0] exp1;
    logic [XLEN-1:0] exp2;
    logic [XLEN-1:0] syn1;
    logic [XLEN-1:0] syn2;
    logic            chk1;
    logic            chk2;
    logic            mis1;
    logic            mis2;
    logic            mis_wr;
    logic            mis_any;
    logic            we;

    logic [CNT_W:0]   cc_sum;
    logic [CNT_W-1:0] cc_d;
    logic [CNT_W-1:0] ec_d;

    // Shadow reads are combinational, so compares see the state from before
    // this retirement's write even when rd equals rs1/rs2.
    regchk_shadow_rf #(
        .XLEN     (XLEN),
        .NUM_REGS (NUM_REGS)
    ) u_shadow (
        .clk    (clk),
        .rst    (rst),
        .clr    (clr),
        .we     (we),
        .waddr  (rvfi_rd_addr),
        .wdata  (rvfi_rd_wdata),
        .raddr1 (rvfi_rs1_addr),
        .rdata1 (rd1),
        .raddr2 (rvfi_rs2_addr),
        .rdata2 (rd2)
    );

    assign we = rvfi_valid && !clr && MON_MASK[rvfi_rd_addr];

    always_comb begin
        // x0 reads always count as a check against an implicit zero.
        exp1 = (rvfi_rs1_addr == '0) ? '0 : rd1[XLEN-1:0];
        exp2 = (rvfi_rs2_addr == '0) ? '0 : rd2[XLEN-1:0];
        chk1 = rvfi_valid && ((rvfi_rs1_addr == '0) ||
                              (MON_MASK[rvfi_rs1_addr] && rd1[XLEN]));
        chk2 = rvfi_valid && ((rvfi_rs2_addr == '0) ||
                              (MON_MASK[rvfi_rs2_addr] && rd2[XLEN]));
        syn1 = exp1 ^ rvfi_rs1_rdata;
        syn2 = exp2 ^ rvfi_rs2_rdata;
        mis1 = chk1 && (syn1 != '0);
        mis2 = chk2 && (syn2 != '0);
        // A nonzero write to x0 is reported as an rs1-port error on x0.
        mis_wr  = rvfi_valid && (rvfi_rd_addr == '0) && (rvfi_rd_wdata != '0);
        mis_any = mis1 || mis2 || mis_wr;
    end

    // Capture priority: rs1 read, then x0 write (also port rs1), then rs2.
    always_comb begin
        cap_d = '0;
        if (mis1) begin
            cap_d.rnum     = CAP_AW_MAX'(rvfi_rs1_addr);
            cap_d.port     = 1'b0;
            cap_d.syndrome = CAP_DW_MAX'(syn1);
        end else if (mis_wr) begin
            cap_d.rnum     = '0;
            cap_d.port     = 1'b0;
            cap_d.syndrome = CAP_DW_MAX'(rvfi_rd_wdata);
        end else begin
            cap_d.rnum     = CAP_AW_MAX'(rvfi_rs2_addr);
            cap_d.port     = 1'b1;
            cap_d.syndrome = CAP_DW_MAX'(syn2);
        end
    end

    always_comb begin
        cc_sum = {1'b0, check_cnt} + {{CNT_W{1'b0}}, chk1} + {{CNT_W{1'b0}}, chk2};
        cc_d   = cc_sum[CNT_W] ? '1 : cc_sum[CNT_W-1:0];
        ec_d   = (err_cnt == '1) ? err_cnt : err_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= RUN;
            cap_q     <= '0;
            check_cnt <= '0;
            err_cnt   <= '0;
        end else if (clr) begin
            state     <= RUN;
            cap_q     <= '0;
            check_cnt <= '0;
            err_cnt   <= '0;
        end else begin
            if (rvfi_valid) begin
                check_cnt <= cc_d;
            end
            case (state)
                RUN: begin
                    if (mis_any) begin
                        state   <= ERROR;
                        cap_q   <= cap_d;
                        err_cnt <= ec_d;
                    end
                end
                ERROR: begin
                    // Sticky mode freezes captures and err_cnt until clr.
                    if (!STICKY) begin
                        if (mis_any) begin
                            cap_q   <= cap_d;
                            err_cnt <= ec_d;
                        end else begin
                            state <= RUN;
                        end
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

    assign err          = (state == ERROR);
    assign err_reg      = cap_q.rnum[AW-1:0];
    assign err_port     = cap_q.port;
    assign err_syndrome = cap_q.syndrome[XLEN-1:0];

    // Upper capture bits only exist to fit the widest configuration.
    logic unused_cap_bits;
    assign unused_cap_bits = ^{cap_q.rnum, cap_q.syndrome};

`ifdef REGCHK_FORMAL
    for (genvar i = 0; i < XLEN; i++) begin : g_syn_assert
        a_syn_zero: assert property (@(posedge clk) disable iff (rst)
                                     err_syndrome[i] == 1'b0);
    end
    a_no_err: assert property (@(posedge clk) disable iff (rst) !err);
`endif

endmodule

`ifdef REGCHK_BIND_IBEX
bind ibex_top regfile_shadow_checker u_regfile_shadow_checker (
    .clk            (clk_i),
    .rst            (!rst_ni),
    .clr            (1'b0),
    .rvfi_valid     (rvfi_valid),
    .rvfi_rd_addr   (rvfi_rd_addr),
    .rvfi_rd_wdata  (rvfi_rd_wdata),
    .rvfi_rs1_addr  (rvfi_rs1_addr),
    .rvfi_rs2_addr  (rvfi_rs2_addr),
    .rvfi_rs1_rdata (rvfi_rs1_rdata),
    .rvfi_rs2_rdata (rvfi_rs2_rdata),
    .err            (),
    .err_syndrome   (),
    .err_reg        (),
    .err_port       (),
    .check_cnt      (),
    .err_cnt        ()
);
`endif

// File: tb/tb_regfile_shadow_checker.sv
// tb/tb_regfile_shadow_checker.sv - self-checking bench for regfile_shadow_checker

module tb_regfile_shadow_checker;

    localparam int CW = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clr = 1'b0;
    logic        rvfi_valid = 1'b0;
    logic [4:0]  rd_a = '0, rs1_a = '0, rs2_a = '0;
    logic [31:0] wd = '0, d1 = '0, d2 = '0;

    logic          err_s, err_n, port_s, port_n;
    logic [31:0]   syn_s, syn_n;
    logic [4:0]    reg_s, reg_n;
    logic [CW-1:0] cc_s, cc_n, ec_s, ec_n;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    regfile_shadow_checker #(.CNT_W(CW), .STICKY(1'b1)) dut_s (
        .clk(clk), .rst(rst), .clr(clr), .rvfi_valid(rvfi_valid),
        .rvfi_rd_addr(rd_a), .rvfi_rd_wdata(wd),
        .rvfi_rs1_addr(rs1_a), .rvfi_rs2_addr(rs2_a),
        .rvfi_rs1_rdata(d1), .rvfi_rs2_rdata(d2),
        .err(err_s), .err_syndrome(syn_s), .err_reg(reg_s), .err_port(port_s),
        .check_cnt(cc_s), .err_cnt(ec_s)
    );

    regfile_shadow_checker #(.CNT_W(CW), .STICKY(1'b0)) dut_n (
        .clk(clk), .rst(rst), .clr(clr), .rvfi_valid(rvfi_valid),
        .rvfi_rd_addr(rd_a), .rvfi_rd_wdata(wd),
        .rvfi_rs1_addr(rs1_a), .rvfi_rs2_addr(rs2_a),
        .rvfi_rs1_rdata(d1), .rvfi_rs2_rdata(d2),
        .err(err_n), .err_syndrome(syn_n), .err_reg(reg_n), .err_port(port_n),
        .check_cnt(cc_n), .err_cnt(ec_n)
    );

    typedef struct packed {
        logic          err;
        logic [4:0]    rnum;
        logic          port;
        logic [31:0]   syn;
        logic [CW-1:0] cc;
        logic [CW-1:0] ec;
    } exp_t;

    exp_t exp_q[$];

    // Reference model: shared shadow, per-instance (0 = sticky, 1 = non-sticky) state.
    logic [31:0] sh [32];
    bit          vld [32];
    bit          m_err [2];
    logic [4:0]  m_reg [2];
    bit          m_port [2];
    logic [31:0] m_syn [2];
    int          m_cc [2];
    int          m_ec [2];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 32; i++) vld[i] = 1'b0;
        for (int k = 0; k < 2; k++) begin
            m_err[k] = 0; m_reg[k] = '0; m_port[k] = 0; m_syn[k] = '0;
            m_cc[k] = 0; m_ec[k] = 0;
        end
    endtask

    task automatic model_step();
        bit c1, c2, m1, m2, mw, mis;
        logic [31:0] s1, s2, csyn;
        logic [4:0]  creg;
        bit          cport;
        exp_t        e;
        c1 = 0; c2 = 0; m1 = 0; m2 = 0; mw = 0; s1 = '0; s2 = '0;
        if (clr) begin
            model_clear();
        end else begin
            if (rvfi_valid) begin
                c1 = (rs1_a == 0) || vld[rs1_a];
                c2 = (rs2_a == 0) || vld[rs2_a];
                s1 = ((rs1_a == 0) ? 32'h0 : sh[rs1_a]) ^ d1;
                s2 = ((rs2_a == 0) ? 32'h0 : sh[rs2_a]) ^ d2;
                m1 = c1 && (s1 != 0);
                m2 = c2 && (s2 != 0);
                mw = (rd_a == 0) && (wd != 0);
            end
            mis = m1 || m2 || mw;
            if (m1)      begin creg = rs1_a; cport = 0; csyn = s1; end
            else if (mw) begin creg = 5'd0;  cport = 0; csyn = wd; end
            else         begin creg = rs2_a; cport = 1; csyn = s2; end
            for (int k = 0; k < 2; k++) begin
                if (rvfi_valid) begin
                    m_cc[k] = m_cc[k] + int'(c1) + int'(c2);
                    if (m_cc[k] > 15) m_cc[k] = 15;
                end
                if (mis && !(k == 0 && m_err[k])) begin
                    m_reg[k] = creg; m_port[k] = cport; m_syn[k] = csyn;
                    if (m_ec[k] < 15) m_ec[k]++;
                    m_err[k] = 1;
                end else if (k == 1) begin
                    m_err[k] = 0;
                end
            end
            if (rvfi_valid && rd_a != 0) begin
                sh[rd_a]  = wd;
                vld[rd_a] = 1;
            end
        end
        for (int k = 0; k < 2; k++) begin
            e.err = m_err[k]; e.rnum = m_reg[k]; e.port = m_port[k]; e.syn = m_syn[k];
            e.cc = CW'(m_cc[k]); e.ec = CW'(m_ec[k]);
            exp_q.push_back(e);
        end
    endtask

    task automatic tick();
        exp_t e;
        model_step();
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check("s.err", err_s, e.err);   check("s.reg", reg_s, e.rnum);
        check("s.port", port_s, e.port); check("s.syn", syn_s, e.syn);
        check("s.cc", cc_s, e.cc);      check("s.ec", ec_s, e.ec);
        e = exp_q.pop_front();
        check("n.err", err_n, e.err);   check("n.reg", reg_n, e.rnum);
        check("n.port", port_n, e.port); check("n.syn", syn_n, e.syn);
        check("n.cc", cc_n, e.cc);      check("n.ec", ec_n, e.ec);
    endtask

    task automatic retire(input logic [4:0] a_rd, input logic [31:0] a_wd,
                          input logic [4:0] a1, input logic [31:0] a_d1,
                          input logic [4:0] a2, input logic [31:0] a_d2);
        rd_a = a_rd; wd = a_wd; rs1_a = a1; d1 = a_d1; rs2_a = a2; d2 = a_d2;
        rvfi_valid = 1'b1;
        tick();
        rvfi_valid = 1'b0;
    endtask

    task automatic idle();
        rvfi_valid = 1'b0;
        tick();
    endtask

    task automatic do_clr();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".err"}, err_s, 0);  check({tag, ".syn"}, syn_s, 0);
        check({tag, ".reg"}, reg_s, 0);  check({tag, ".port"}, port_s, 0);
        check({tag, ".cc"}, cc_s, 0);    check({tag, ".ec"}, ec_s, 0);
        check({tag, ".n_err"}, err_n, 0); check({tag, ".n_cc"}, cc_n, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;

        // Read before any write is not checked.
        retire(5'd0, 32'h0, 5'd5, 32'h12345678, 5'd6, 32'h0);
        check("unwritten.cc", cc_s, 0);
        check("unwritten.err", err_s, 0);

        // Write then matching read on the next retirement.
        retire(5'd7, 32'hDEADBEEF, 5'd8, 32'h0, 5'd9, 32'h0);
        retire(5'd0, 32'h0, 5'd7, 32'hDEADBEEF, 5'd10, 32'h0);
        check("match.err", err_s, 0);
        check("match.cc", cc_s, 1);
        do_clr();
        check_all_zero("clr1");

        // rd == rs1: read checked against old value, shadow takes new value.
        retire(5'd3, 32'd5, 5'd11, 32'h0, 5'd12, 32'h0);
        retire(5'd3, 32'd9, 5'd3, 32'd5, 5'd13, 32'h0);
        retire(5'd0, 32'h0, 5'd3, 32'd9, 5'd14, 32'h0);
        check("rdrs.err", err_s, 0);
        check("rdrs.cc", cc_s, 2);
        do_clr();

        // rs2 mismatch on x7.
        retire(5'd7, 32'hDEADBEEF, 5'd15, 32'h0, 5'd16, 32'h0);
        retire(5'd0, 32'h0, 5'd15, 32'h0, 5'd7, 32'hDEADBEEE);
        check("rs2.err", err_s, 1);
        check("rs2.reg", reg_s, 7);
        check("rs2.port", port_s, 1);
        check("rs2.syn", syn_s, 32'h1);
        check("rs2.ec", ec_s, 1);
        do_clr();

        // Both ports mismatch, then a second error while sticky.
        retire(5'd1, 32'hA5A50000, 5'd16, 32'h0, 5'd17, 32'h0);
        retire(5'd2, 32'h00005A5A, 5'd16, 32'h0, 5'd17, 32'h0);
        retire(5'd0, 32'h0, 5'd1, 32'hA5A50010, 5'd2, 32'h00005A7A);
        check("both.reg", reg_s, 1);
        check("both.port", port_s, 0);
        check("both.syn", syn_s, 32'h10);
        check("both.ec", ec_s, 1);
        check("both.cc", cc_s, 2);
        retire(5'd0, 32'h0, 5'd2, 32'h00005AA5, 5'd18, 32'h0);
        check("sticky.reg", reg_s, 1);
        check("sticky.syn", syn_s, 32'h10);
        check("sticky.ec", ec_s, 1);
        idle();
        check("sticky.err", err_s, 1);
        check("nonsticky.err", err_n, 0);
        do_clr();
        check_all_zero("clr2");

        // Retirement coinciding with clr is dropped.
        rd_a = 5'd23; wd = 32'h77; rs1_a = 5'd24; d1 = '0; rs2_a = 5'd25; d2 = '0;
        rvfi_valid = 1'b1;
        do_clr();
        rvfi_valid = 1'b0;
        retire(5'd0, 32'h0, 5'd23, 32'h1234, 5'd0, 32'h0);
        check("clrdrop.err", err_s, 0);
        check("clrdrop.cc", cc_s, 1);
        do_clr();

        // x0 read with nonzero data, then asynchronous reset mid-stream.
        retire(5'd7, 32'h11111111, 5'd19, 32'h0, 5'd20, 32'h0);
        retire(5'd0, 32'h0, 5'd0, 32'h1, 5'd19, 32'h0);
        check("x0rd.err", err_s, 1);
        check("x0rd.reg", reg_s, 0);
        check("x0rd.syn", syn_s, 32'h1);
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("async_rst");
        model_clear();
        @(posedge clk);
        #1;
        rst = 1'b0;
        retire(5'd0, 32'h0, 5'd7, 32'h22222222, 5'd20, 32'h0);
        check("postrst.err", err_s, 0);
        check("postrst.cc", cc_s, 0);

        // Nonzero write to x0.
        retire(5'd0, 32'h55, 5'd21, 32'h0, 5'd22, 32'h0);
        check("x0wr.err", err_s, 1);
        check("x0wr.reg", reg_s, 0);
        check("x0wr.port", port_s, 0);
        do_clr();

        // Counter saturation.
        for (int i = 0; i < 17; i++) begin
            retire(5'd0, 32'h0, 5'd0, 32'(i + 1), 5'd0, 32'h0);
        end
        check("sat.cc", cc_s, 15);
        check("sat.n_cc", cc_n, 15);
        check("sat.n_ec", ec_n, 15);
        check("sat.ec", ec_s, 1);
        check("sat.n_syn", syn_n, 32'd17);
        idle();
        check("sat.n_err_drop", err_n, 0);
        check("queue_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_shadow_checker.md
# regfile_shadow_checker

Parametrised RVFI-side consistency monitor for the whole integer register file of the ibex core. It keeps a shadow copy of every monitored architectural register, built from retired writes. On each retirement it checks both source-operand reads against that copy. Mismatches are reported as per-bit syndromes, a latched first-error record and saturating counters. It is bound into ibex_top alongside the other formal property modules and drives per-bit assertions.

## Interface
Parameters:
- XLEN, 32, register and data width
- NUM_REGS, 32, architectural registers (16 for RV32E); address width is $clog2(NUM_REGS)
- CHECK_MASK, {NUM_REGS{1'b1}}, bit i set = register xi monitored; bit 0 is ignored (x0 handled separately)
- STICKY, 1, 1 = first error latches the FSM in ERROR until clr; 0 = continue checking after error
- CNT_W, 16, width of the check and error counters

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- clr  in  1  synchronous clear of error state, counters and shadow valid bits
- rvfi_valid  in  1  retirement strobe
- rvfi_rd_addr  in  AW  destination register
- rvfi_rd_wdata  in  XLEN  write data
- rvfi_rs1_addr, rvfi_rs2_addr  in  AW  source registers
- rvfi_rs1_rdata, rvfi_rs2_rdata  in  XLEN  read data
- err  out  1  error flag
- err_syndrome  out  XLEN  XOR of shadow and read data for the captured error
- err_reg  out  AW  register of the captured error
- err_port  out  1  0 = rs1, 1 = rs2
- check_cnt  out  CNT_W  reads actually compared (saturating)
- err_cnt  out  CNT_W  retirements with ≥1 mismatch (saturating)

## Operation
- Shadow array is NUM_REGS×XLEN, with one valid bit per register. A register is compared only when its valid bit is set and its CHECK_MASK bit is set.
- Checks are evaluated against shadow state before the current retirement's write (RVFI semantics).
- If rd == rs, the read is checked against the old value, then the shadow takes the new value.
- Write: if rvfi_valid, rd≠0 and rd is monitored, set shadow[rd] = rd_wdata and valid[rd] = 1.
- x0:
  - Any rs1/rs2 read of x0 with nonzero rdata is a mismatch. It counts as a check with shadow value 0.
  - rd = 0 with nonzero wdata is a mismatch on port rs1 with err_reg = 0.
- Both ports are compared in the same cycle. If both mismatch, rs1 is captured and err_cnt increments by 1.
- FSM (package enum):
  - RUN to ERROR on the first mismatch; the capture registers load at that edge.
  - ERROR to RUN on clr.
  - In ERROR with STICKY=1: captures hold, err_cnt stops, shadow updates continue.
  - STICKY=0: FSM returns to RUN on the next cycle; captures load on every mismatch; err stays high only in the cycle after a mismatch.
- clr:
  - Returns FSM to RUN, zeroes counters and captures, and clears all valid bits.
  - Has priority over a simultaneous retirement, which is dropped.
- Counters saturate at all-ones with no wrap.
- Formal: one assertion per syndrome bit, err_syndrome[i] == 0 for i in 0..XLEN-1, plus one assertion that err is 0.

## Timing
- Reset values: err = 0, err_syndrome = 0, err_reg = 0, err_port = 0, check_cnt = 0, err_cnt = 0, all valid bits 0, FSM = RUN. Shadow data is not reset.
- Reset mid-stream: all of the above is restored asynchronously. The first retirement after deassertion is treated as the first post-reset instruction.
- Latency: a mismatching retirement at edge N raises err and loads the captures at edge N; they are visible from N+1.
- Written data is checkable on the very next retirement (the following cycle).
- No backpressure; every rvfi_valid cycle is consumed.
- rvfi_valid = 0 cycles change nothing.

## Structure
- Package regchk_pkg: the state enum (RUN, ERROR), the error-capture struct {reg, port, syndrome}, and a localparam function for the address width.
- Sub-module regchk_shadow_rf: shadow array plus valid bits, 1 write port, 2 asynchronous read ports, and clear-all. It returns {valid, data} per read port.
- Top module: compare logic, FSM, counters, assertion generate loop, and the bind statement to ibex_top.

## Test plan
- Write x7 = 0xDEADBEEF, then read rs1 = x7 with 0xDEADBEEF → err stays 0, check_cnt = 1.
- Write x7 = 0xDEADBEEF, then read rs2 = x7 with 0xDEADBEEE → from the next cycle err = 1, err_reg = 7, err_port = 1, err_syndrome = 0x00000001, err_cnt = 1.
- Read x5 before any write with 0x12345678 → no check; check_cnt = 0, err = 0.
- Single retirement with rd = rs1 = x3, shadow x3 = 5, rs1_rdata = 5, wdata = 9; next retirement reads x3 = 9 → no error, check_cnt = 2.
- STICKY = 1: both ports mismatch (x1 syndrome 0x10, x2 syndrome 0x20), then a second error, then clr → captures show x1/rs1/0x10 and err_cnt = 1 until clr; after clr all outputs = 0.
- Read x0 with rdata = 0x1; also rst asserted mid-stream → err_reg = 0, syndrome = 0x1; rst clears everything asynchronously, and a following read of x7 is not checked.
